// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in parallel-out framer.
package sipo_pkg;

   typedef enum logic {
      HUNT  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Word-wide shift register with selectable direction and word-start clear.
module sipo_shift_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             first,
   input  logic             lsb_first,
   input  logic             din,
   output logic [WIDTH-1:0] nxt
);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] base;

   // nxt is the register value after this edge's bit, so the
   // framer can capture a completed word on the same edge.
   always_comb begin
      base = first ? '0 : q;
      if (lsb_first) nxt = {din, base[WIDTH-1:1]};
      else           nxt = {base[WIDTH-2:0], din};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     q <= '0;
      else if (en) q <= nxt;
   end

endmodule

// File: rtl/sipo_framer.sv
// Deserialiser: frames serial bits into words and presents them on a
// valid/ready port, flagging words dropped while the output is held.
module sipo_framer
   import sipo_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter bit SYNC_ON_START = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     serial_in,
   input  logic                     bit_valid,
   input  logic                     frame_start,
   input  logic                     lsb_first,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         parallel_out,
   output logic                     out_valid,
   output logic                     overrun,
   output logic [clog2(WIDTH)-1:0]  bit_count
);

   localparam int CW = clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam state_t RST_STATE = SYNC_ON_START ? HUNT : SHIFT;

   state_t           state;
   logic             order;
   logic             accept;
   logic             first;
   logic             complete;
   logic             load;
   logic             dir;
   logic [WIDTH-1:0] word;

   // frame_start on the would-be last bit restarts the word, so a
   // first bit can never also complete one.
   always_comb begin
      accept   = bit_valid && (state == SHIFT || frame_start);
      first    = frame_start || (bit_count == '0);
      complete = accept && !first && (bit_count == LAST);
      load     = complete && (!out_valid || out_ready);
      dir      = first ? lsb_first : order;
   end

   sipo_shift_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .en       (accept),
      .first    (first),
      .lsb_first(dir),
      .din      (serial_in),
      .nxt      (word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= RST_STATE;
         order        <= 1'b0;
         bit_count    <= '0;
         parallel_out <= '0;
         out_valid    <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         overrun <= complete && !load;
         if (load) begin
            parallel_out <= word;
            out_valid    <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            state <= SHIFT;
            if (first) begin
               order     <= lsb_first;
               bit_count <= CW'(1);
            end else if (complete) begin
               bit_count <= '0;
            end else begin
               bit_count <= bit_count + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_sipo_framer.sv
// Directed bench for sipo_framer at WIDTH=4, free-running and frame-synced.
module tb_sipo_framer;

   logic       clk;
   logic       rst;
   logic       serial_in;
   logic       bit_valid;
   logic       frame_start;
   logic       lsb_first;
   logic       out_ready;
   logic [3:0] pout0, pout1;
   logic       valid0, valid1;
   logic       ovr0, ovr1;
   logic [1:0] cnt0, cnt1;

   int n_chk;
   int n_fail;

   sipo_framer #(.WIDTH(4), .SYNC_ON_START(1'b0)) dut0 (
      .clk         (clk),
      .rst         (rst),
      .serial_in   (serial_in),
      .bit_valid   (bit_valid),
      .frame_start (frame_start),
      .lsb_first   (lsb_first),
      .out_ready   (out_ready),
      .parallel_out(pout0),
      .out_valid   (valid0),
      .overrun     (ovr0),
      .bit_count   (cnt0)
   );

   sipo_framer #(.WIDTH(4), .SYNC_ON_START(1'b1)) dut1 (
      .clk         (clk),
      .rst         (rst),
      .serial_in   (serial_in),
      .bit_valid   (bit_valid),
      .frame_start (frame_start),
      .lsb_first   (lsb_first),
      .out_ready   (out_ready),
      .parallel_out(pout1),
      .out_valid   (valid1),
      .overrun     (ovr1),
      .bit_count   (cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sb(input logic b, input logic fs);
      serial_in   = b;
      bit_valid   = 1'b1;
      frame_start = fs;
      step();
      bit_valid   = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic idle();
      bit_valid   = 1'b0;
      frame_start = 1'b0;
      step();
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst = 1'b1;
      serial_in = 1'b0;
      bit_valid = 1'b0;
      frame_start = 1'b0;
      lsb_first = 1'b0;
      out_ready = 1'b1;
      #12;
      chk("rst_pout", pout0, 4'h0);
      chk("rst_valid", valid0, 1'b0);
      chk("rst_ovr", ovr0, 1'b0);
      chk("rst_cnt", cnt0, 2'd0);
      chk("rst_valid1", valid1, 1'b0);
      rst = 1'b0;
      step();

      // MSB-first 1,0,1,1
      sb(1'b1, 1'b0);
      sb(1'b0, 1'b0);
      sb(1'b1, 1'b0);
      chk("msb_cnt3", cnt0, 2'd3);
      chk("msb_valid_early", valid0, 1'b0);
      sb(1'b1, 1'b0);
      chk("msb_pout", pout0, 4'b1011);
      chk("msb_valid", valid0, 1'b1);
      chk("msb_cnt_wrap", cnt0, 2'd0);
      chk("hunt_cnt1", cnt1, 2'd0);
      chk("hunt_valid1", valid1, 1'b0);
      idle();
      chk("msb_valid_drop", valid0, 1'b0);

      // LSB-first, order toggled mid-word
      lsb_first = 1'b1;
      sb(1'b1, 1'b0);
      lsb_first = 1'b0;
      sb(1'b0, 1'b0);
      sb(1'b1, 1'b0);
      sb(1'b1, 1'b0);
      chk("lsb_pout", pout0, 4'b1101);
      chk("lsb_valid", valid0, 1'b1);
      idle();

      // Sync: stray bits then framed 0,1,1,0
      sb(1'b1, 1'b0);
      sb(1'b1, 1'b0);
      chk("sync_ignored", cnt1, 2'd0);
      sb(1'b0, 1'b1);
      chk("sync_cnt", cnt1, 2'd1);
      sb(1'b1, 1'b0);
      sb(1'b1, 1'b0);
      chk("sync_valid_early", valid1, 1'b0);
      sb(1'b0, 1'b0);
      chk("sync_pout", pout1, 4'b0110);
      chk("sync_valid", valid1, 1'b1);
      chk("sync_pout0", pout0, 4'b0110);
      idle();

      // Overrun: A held, B dropped, C loads on ready
      out_ready = 1'b0;
      sb(1'b1, 1'b0);
      sb(1'b0, 1'b0);
      sb(1'b0, 1'b0);
      sb(1'b1, 1'b0);
      chk("ovr_A_pout", pout0, 4'b1001);
      chk("ovr_A_valid", valid0, 1'b1);
      chk("ovr_A_none", ovr0, 1'b0);
      sb(1'b0, 1'b0);
      sb(1'b1, 1'b0);
      sb(1'b1, 1'b0);
      sb(1'b1, 1'b0);
      chk("ovr_B_pulse", ovr0, 1'b1);
      chk("ovr_B_hold", pout0, 4'b1001);
      chk("ovr_B_valid", valid0, 1'b1);
      idle();
      chk("ovr_pulse_end", ovr0, 1'b0);
      chk("ovr_hold2", pout0, 4'b1001);
      sb(1'b1, 1'b0);
      sb(1'b1, 1'b0);
      sb(1'b0, 1'b0);
      out_ready = 1'b1;
      sb(1'b0, 1'b0);
      chk("ovr_C_pout", pout0, 4'b1100);
      chk("ovr_C_valid", valid0, 1'b1);
      chk("ovr_C_none", ovr0, 1'b0);
      idle();
      chk("ovr_C_drain", valid0, 1'b0);

      // frame_start on 3rd bit
      sb(1'b1, 1'b0);
      sb(1'b1, 1'b0);
      sb(1'b0, 1'b1);
      chk("fs3_cnt", cnt0, 2'd1);
      sb(1'b1, 1'b0);
      sb(1'b0, 1'b0);
      sb(1'b1, 1'b0);
      chk("fs3_pout", pout0, 4'b0101);
      idle();

      // frame_start on would-be last bit
      sb(1'b1, 1'b0);
      sb(1'b1, 1'b0);
      sb(1'b1, 1'b0);
      sb(1'b0, 1'b1);
      chk("fs4_valid", valid0, 1'b0);
      chk("fs4_ovr", ovr0, 1'b0);
      chk("fs4_cnt", cnt0, 2'd1);
      sb(1'b0, 1'b0);
      sb(1'b1, 1'b0);
      sb(1'b1, 1'b0);
      chk("fs4_pout", pout0, 4'b0011);

      // Async reset mid-word with a held word
      out_ready = 1'b0;
      sb(1'b1, 1'b0);
      sb(1'b0, 1'b0);
      chk("pre_rst_valid", valid0, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_pout", pout0, 4'h0);
      chk("arst_valid", valid0, 1'b0);
      chk("arst_cnt", cnt0, 2'd0);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      step();
      sb(1'b0, 1'b0);
      idle();
      idle();
      sb(1'b1, 1'b0);
      idle();
      sb(1'b1, 1'b0);
      idle();
      idle();
      idle();
      chk("gap_cnt", cnt0, 2'd3);
      sb(1'b1, 1'b0);
      chk("gap_pout", pout0, 4'b0111);
      chk("gap_valid", valid0, 1'b1);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
